// File: rtl/mdu_hilo.sv
// mdu_hilo -- execute-stage multiply/divide unit with HI/LO registers.
//
// A mult/multu/div/divu accepted in IDLE latches its operands. The unit then
// reports Busy for exactly MULT_CYCLES or DIV_CYCLES cycles. The result is
// written to HI/LO on the last busy edge. mthi/mtlo write HI/LO directly, in a
// single cycle. Any Start seen while busy is dropped; the hazard unit must
// stall the pipeline instead.
//
// Ports:
//   clk    in   1  clock, rising-edge
//   reset  in   1  synchronous active-low reset
//   Start  in   1  qualifies MDUOp
//   MDUOp  in   3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none
//   A      in  32  rs operand
//   B      in  32  rt operand
//   Busy   out  1  mult/div in flight
//   HI     out 32  HI register
//   LO     out 32  LO register
module mdu_hilo #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = (MAX_CYC < 16) ? 4 : $clog2(MAX_CYC) + 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_a;
  logic [31:0]        r_b;
  logic               r_signed;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;

  // Op decode, used only in IDLE
  logic w_start_mul;
  logic w_start_div;
  logic w_op_signed;
  assign w_start_mul = Start && (MDUOp == 3'd1 || MDUOp == 3'd2);
  assign w_start_div = Start && (MDUOp == 3'd3 || MDUOp == 3'd4);
  assign w_op_signed = (MDUOp == 3'd1) || (MDUOp == 3'd3);

  logic w_mul_done;
  logic w_div_done;
  assign w_mul_done = (r_cnt == CNT_W'(MULT_CYCLES));
  assign w_div_done = (r_cnt == CNT_W'(DIV_CYCLES));

  // Multiply: sign/zero-extend to 64 bits. The low 64 bits of the product
  // are then correct for both signed and unsigned operands.
  logic [63:0] w_a_ext;
  logic [63:0] w_b_ext;
  logic [63:0] w_prod;
  assign w_a_ext = {{32{r_signed & r_a[31]}}, r_a};
  assign w_b_ext = {{32{r_signed & r_b[31]}}, r_b};
  assign w_prod  = w_a_ext * w_b_ext;

  // Divide on magnitudes, then restore the signs. Quotient sign is the XOR of
  // the operand signs; remainder follows the dividend. 0x80000000 / -1 falls
  // out as 0x80000000 with no special case. The zero divisor is replaced by 1
  // only to keep the divider defined, because that result is never committed.
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_b_div;
  logic [31:0] w_uq;
  logic [31:0] w_ur;
  logic [31:0] w_quot;
  logic [31:0] w_rem;
  logic        w_b_zero;
  assign w_a_neg  = r_signed & r_a[31];
  assign w_b_neg  = r_signed & r_b[31];
  assign w_a_mag  = w_a_neg ? (32'd0 - r_a) : r_a;
  assign w_b_mag  = w_b_neg ? (32'd0 - r_b) : r_b;
  assign w_b_zero = (r_b == 32'd0);
  assign w_b_div  = w_b_zero ? 32'd1 : w_b_mag;
  assign w_uq     = w_a_mag / w_b_div;
  assign w_ur     = w_a_mag % w_b_div;
  assign w_quot   = (w_a_neg ^ w_b_neg) ? (32'd0 - w_uq) : w_uq;
  assign w_rem    = w_a_neg ? (32'd0 - w_ur) : w_ur;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_mul)      w_state_next = S_MUL;
        else if (w_start_div) w_state_next = S_DIV;
      end
      S_MUL:   if (w_mul_done) w_state_next = S_IDLE;
      S_DIV:   if (w_div_done) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output logic: Busy comes only from the state register
  always_comb begin
    Busy = (r_state != S_IDLE);
  end

  // Datapath: operand latch, cycle counter, HI/LO
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_signed <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_mul || w_start_div) begin
            r_a      <= A;
            r_b      <= B;
            r_signed <= w_op_signed;
            r_cnt    <= CNT_W'(1);
          end else if (Start && MDUOp == 3'd5) begin
            r_hi <= A;
          end else if (Start && MDUOp == 3'd6) begin
            r_lo <= A;
          end
        end
        S_MUL: begin
          if (w_mul_done) begin
            r_hi  <= w_prod[63:32];
            r_lo  <= w_prod[31:0];
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DIV: begin
          if (w_div_done) begin
            // Divide by zero leaves HI/LO untouched
            if (!w_b_zero) begin
              r_hi <= w_rem;
              r_lo <= w_quot;
            end
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign HI = r_hi;
  assign LO = r_lo;

endmodule
